// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory responder.
//   state_t    : responder FSM states (IDLE, WAIT, RESP)
//   SZ_*       : legal transfer sizes in bytes
//   size_legal : size is one of 1/2/4/8 and the address is naturally aligned
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    // Only the low three address bits matter for natural alignment of <= 8 bytes.
    function automatic logic size_legal(input logic [3:0] size, input logic [2:0] addr_lo);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (addr_lo[0] == 1'b0);
            SZ_W:    ok = (addr_lo[1:0] == 2'b00);
            SZ_D:    ok = (addr_lo == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational lane logic for an 8-byte little-endian window starting at the
// request address.
//   size    in  : transfer size in bytes (1/2/4/8; anything else -> no lanes)
//   win     in  : raw bytes mem[addr+0] .. mem[addr+7], byte 0 in bits 7:0
//   rdata   out : window masked to the transfer size, upper bytes zero
//   byte_en out : per-byte write enables for a store of this size
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [3:0]  size,
    input  logic [63:0] win,
    output logic [63:0] rdata,
    output logic [7:0]  byte_en
);

    always_comb begin
        byte_en = 8'h00;
        case (size)
            SZ_B:    byte_en = 8'h01;
            SZ_H:    byte_en = 8'h03;
            SZ_W:    byte_en = 8'h0F;
            SZ_D:    byte_en = 8'hFF;
            default: byte_en = 8'h00;
        endcase
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = byte_en[i] ? win[8*i +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/datamem_responder.sv
// -----------------------------------------------------------------------------
// datamem_responder
// Fixed-latency data memory for the CPU load/store path. One request is
// accepted at a time; the memory action happens LATENCY cycles after the
// accept edge and the result is held until the response handshake.
//   clk, reset               : clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake (ready only in IDLE)
//   req_write                : 1 = store, 0 = load
//   req_addr, req_wdata      : byte address, store data (low size*8 bits used)
//   req_size                 : bytes per transfer (1/2/4/8)
//   resp_valid / resp_ready  : response handshake
//   resp_rdata               : zero-extended load data, 0 for stores/errors
//   resp_error               : illegal request, no memory side effect
// Parameters: DEPTH_BYTES (power of two, >= 8), LATENCY (>= 1).
// -----------------------------------------------------------------------------
module datamem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error
);

    localparam int AW = $clog2(DEPTH_BYTES);
    // Counter only ever holds LATENCY-1 down to 0.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [3:0]    size_q, size_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          error_q, error_d;

    logic [7:0]    mem_q [DEPTH_BYTES];
    logic          mem_we;

    logic [63:0]   win;
    logic [63:0]   lane_rdata;
    logic [7:0]    byte_en;
    logic [64:0]   end_addr;
    logic          access_ok;

    // Raw window at the latched address; indices wrap in AW bits, which only
    // matters for requests that are rejected by the range check anyway.
    always_comb begin
        win = '0;
        for (int i = 0; i < 8; i++) begin
            win[8*i +: 8] = mem_q[addr_q[AW-1:0] + AW'(i)];
        end
    end

    dmem_lane_align u_lane_align (
        .size    (size_q),
        .win     (win),
        .rdata   (lane_rdata),
        .byte_en (byte_en)
    );

    // 65-bit end address so a request that wraps past 2^64 is out of range.
    assign end_addr  = {1'b0, addr_q} + {61'd0, size_q};
    assign access_ok = size_legal(size_q, addr_q[2:0]) &&
                       (end_addr <= 65'(DEPTH_BYTES));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        error_d = error_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Every latency, including 1, passes through WAIT so that
                // resp_valid rises exactly LATENCY edges after the accept.
                if (cnt_q == '0) begin
                    mem_we  = access_ok && write_q;
                    error_d = !access_ok;
                    rdata_d = (access_ok && !write_q) ? lane_rdata : 64'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    rdata_d = 64'd0;
                    error_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 64'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Latched request fields carry no reset; they are reloaded on every accept.
    always_ff @(posedge clk) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        size_q  <= size_d;
    end

    // Reset on the memory-action edge aborts the store.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem_q[addr_q[AW-1:0] + AW'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

endmodule

// File: tb/tb_datamem_responder.sv
module tb_datamem_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=3 instance
    logic        reset, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
    logic [63:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_size;

    // LATENCY=1 instance
    logic        l1_reset, l1_req_valid, l1_req_ready, l1_req_write, l1_resp_valid, l1_resp_ready, l1_resp_error;
    logic [63:0] l1_req_addr, l1_req_wdata, l1_resp_rdata;
    logic [3:0]  l1_req_size;

    int n_cmp  = 0;
    int n_fail = 0;

    datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(l1_reset),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
        .req_addr(l1_req_addr), .req_wdata(l1_req_wdata), .req_size(l1_req_size),
        .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
        .resp_rdata(l1_resp_rdata), .resp_error(l1_resp_error)
    );

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
        logic [63:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input bit wr, input logic [63:0] a, input logic [63:0] wd,
                           input logic [3:0] sz, input logic [63:0] er, input bit ee);
        vecs[i].wr        = wr;
        vecs[i].addr      = a;
        vecs[i].wdata     = wd;
        vecs[i].size      = sz;
        vecs[i].exp_rdata = er;
        vecs[i].exp_err   = ee;
    endtask

    // Called at posedge+1. Returns the response and the number of edges from
    // the accept edge until resp_valid was seen.
    task automatic do_req(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                          input logic [3:0] sz, output logic [63:0] rd, output logic er,
                          output int lat);
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_size  = sz;
        req_valid = 1'b1;
        chk("req_ready before accept", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_error;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_valid/req_ready after handshake", {62'd0, resp_valid, req_ready}, 64'h1);
    endtask

    task automatic wait_resp(input string name);
        int k;
        k = 0;
        while (!resp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, resp_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        logic [63:0] l1_exp [4];
        int          ti;
        int          ri;
        bit          acc;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 4'd8; resp_ready = 1'b0;
        l1_reset = 1'b1; l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_addr = '0;
        l1_req_wdata = '0; l1_req_size = 4'd8; l1_resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", req_ready, 1);
        chk("reset resp_valid", resp_valid, 0);
        chk("reset resp_rdata", resp_rdata, 0);
        chk("reset resp_error", resp_error, 0);
        chk("l1 reset req_ready", l1_req_ready, 1);
        chk("l1 reset resp_valid", l1_resp_valid, 0);
        reset = 1'b0;
        l1_reset = 1'b0;

        //          i   wr    addr                    wdata                   size  exp_rdata               err
        set_vec( 0, 1, 64'h10,                 64'h0123_4567_89AB_CDEF, 4'd8, 64'h0,                  0);
        set_vec( 1, 0, 64'h10,                 64'h0,                   4'd8, 64'h0123_4567_89AB_CDEF, 0);
        set_vec( 2, 1, 64'h11,                 64'hAAAA_AAAA_AAAA_AAFF, 4'd1, 64'h0,                  0);
        set_vec( 3, 0, 64'h10,                 64'h0,                   4'd8, 64'h0123_4567_89AB_FFEF, 0);
        set_vec( 4, 0, 64'h12,                 64'h0,                   4'd2, 64'h0000_0000_0000_89AB, 0);
        set_vec( 5, 0, 64'h13,                 64'h0,                   4'd4, 64'h0,                  1);
        set_vec( 6, 1, 64'h3F8,                64'h1122_3344_5566_7788, 4'd8, 64'h0,                  0);
        set_vec( 7, 1, 64'(DEPTH - 4),         64'hDEAD_BEEF_DEAD_BEEF, 4'd8, 64'h0,                  1);
        set_vec( 8, 0, 64'(DEPTH - 8),         64'h0,                   4'd8, 64'h1122_3344_5566_7788, 0);
        set_vec( 9, 0, 64'h10,                 64'h0,                   4'd3, 64'h0,                  1);
        set_vec(10, 1, 64'h0,                  64'h0F0E_0D0C_0B0A_0908, 4'd8, 64'h0,                  0);
        set_vec(11, 1, 64'(DEPTH),             64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 64'h0,                  1);
        set_vec(12, 0, 64'h0,                  64'h0,                   4'd8, 64'h0F0E_0D0C_0B0A_0908, 0);
        set_vec(13, 1, 64'h20,                 64'h0,                   4'd8, 64'h0,                  0);
        set_vec(14, 1, 64'h20,                 64'hFFFF_FFFF_CAFE_BABE, 4'd4, 64'h0,                  0);
        set_vec(15, 0, 64'h20,                 64'h0,                   4'd8, 64'h0000_0000_CAFE_BABE, 0);
        set_vec(16, 0, 64'h22,                 64'h0,                   4'd1, 64'h0000_0000_0000_00FE, 0);
        set_vec(17, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                  4'd8, 64'h0,                  1);
        set_vec(18, 1, 64'h3FF,                64'hFFFF_FFFF_FFFF_FF5A, 4'd1, 64'h0,                  0);
        set_vec(19, 0, 64'h3FF,                64'h0,                   4'd1, 64'h0000_0000_0000_005A, 0);
        set_vec(20, 0, 64'h3F8,                64'h0,                   4'd0, 64'h0,                  1);
        set_vec(21, 0, 64'h3FE,                64'h0,                   4'd2, 64'h0000_0000_0000_5A22, 0);

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, rd, er, lat);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d error", i), er, vecs[i].exp_err);
            chk($sformatf("vec%0d latency", i), lat, 3);
        end

        // Backpressure: response held for 5 cycles while a store is offered.
        req_write = 1'b0; req_addr = 64'h10; req_size = 4'd8; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp("bp resp_valid rises");
        req_write = 1'b1; req_wdata = 64'h0; req_addr = 64'h10; req_size = 4'd8; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp c%0d resp_valid", c), resp_valid, 1);
            chk($sformatf("bp c%0d resp_rdata", c), resp_rdata, 64'h0123_4567_89AB_FFEF);
            chk($sformatf("bp c%0d resp_error", c), resp_error, 0);
            chk($sformatf("bp c%0d req_ready", c), req_ready, 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp resp_valid after handshake", resp_valid, 0);
        chk("bp req_ready after handshake", req_ready, 1);
        do_req(1'b0, 64'h10, 64'h0, 4'd8, rd, er, lat);
        chk("bp ignored store not committed", rd, 64'h0123_4567_89AB_FFEF);

        // Reset on the memory-action edge of a store.
        req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'hBADB_ADBA_DBAD_BAD0; req_size = 4'd8;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst-wait req_ready", req_ready, 1);
        chk("rst-wait resp_valid", resp_valid, 0);
        chk("rst-wait resp_rdata", resp_rdata, 0);
        chk("rst-wait resp_error", resp_error, 0);
        reset = 1'b0;
        do_req(1'b0, 64'h10, 64'h0, 4'd8, rd, er, lat);
        chk("rst-wait store aborted", rd, 64'h0123_4567_89AB_FFEF);

        // Reset while the store response is pending.
        req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'h5555_6666_7777_8888; req_size = 4'd8;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp("rst-resp resp_valid rises");
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst-resp req_ready", req_ready, 1);
        chk("rst-resp resp_valid", resp_valid, 0);
        reset = 1'b0;
        do_req(1'b0, 64'h10, 64'h0, 4'd8, rd, er, lat);
        chk("rst-resp store persists", rd, 64'h5555_6666_7777_8888);

        // LATENCY=1: request held valid, resp_ready tied high.
        l1_exp[0] = 64'h0;
        l1_exp[1] = 64'hA1B2_C3D4_E5F6_0718;
        l1_exp[2] = 64'h0;
        l1_exp[3] = 64'h0000_0000_0000_0018;
        ti = 0;
        ri = 0;
        l1_req_write = 1'b1; l1_req_addr = 64'h40; l1_req_wdata = 64'hA1B2_C3D4_E5F6_0718;
        l1_req_size = 4'd8; l1_req_valid = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            chk($sformatf("l1 c%0d req_ready", cyc), l1_req_ready, 64'((cyc % 3) == 0));
            chk($sformatf("l1 c%0d resp_valid", cyc), l1_resp_valid, 64'((cyc % 3) == 2));
            if ((cyc % 3) == 2 && ri < 4) begin
                chk($sformatf("l1 resp%0d rdata", ri), l1_resp_rdata, l1_exp[ri]);
                chk($sformatf("l1 resp%0d error", ri), l1_resp_error, 0);
                ri++;
            end
            acc = ((cyc % 3) == 0);
            @(posedge clk); #1;
            if (acc) begin
                ti++;
                case (ti)
                    1: begin l1_req_write = 1'b0; l1_req_addr = 64'h40; l1_req_size = 4'd8; end
                    2: begin l1_req_write = 1'b1; l1_req_addr = 64'h41; l1_req_wdata = 64'h0; l1_req_size = 4'd1; end
                    3: begin l1_req_write = 1'b0; l1_req_addr = 64'h40; l1_req_size = 4'd2; end
                    default: l1_req_valid = 1'b0;
                endcase
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
